// File: rtl/joy_poller_pkg.sv
// Shared constants and FSM state encoding for the joypad poller.
package joy_poller_pkg;

   localparam logic [7:0] FS_SIG_P0 = 8'h08;
   localparam logic [7:0] FS_SIG_P1 = 8'h04;

   typedef enum logic [1:0] {
      ST_GAP    = 2'd0,
      ST_LATCH  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_CLK    = 2'd3
   } joy_state_e;

endpackage

// File: rtl/joy_port_shifter.sv
// Console-side serial shifter for one joypad port: parallel load while the
// console strobes, shift on each falling edge of the port read clock.
module joy_port_shifter #(
   parameter int W = 24
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         ser_clk,
   output logic         ser_out
);

   logic [W-1:0] shift;
   logic         last_clk;

   // Load has priority over a coincident falling edge; ones fill from the top.
   always_ff @(posedge clock) begin
      if (reset) begin
         shift    <= '0;
         last_clk <= 1'b0;
      end else begin
         last_clk <= ser_clk;
         if (load) begin
            shift <= load_val;
         end else if (last_clk && !ser_clk) begin
            shift <= {1'b1, shift[W-1:1]};
         end
      end
   end

   assign ser_out = shift[0];

endmodule

// File: rtl/joy_poller.sv
// Polls serial joypads over a shared strobe/clock pair, publishes a tear-free
// snapshot, and serves it to the console's two joypad ports.
//
//  state     | meaning
//  ST_GAP    | idle between frames, strobe=0 clk=0 (POLL_GAP ticks)
//  ST_LATCH  | strobe high, pads latch buttons (2 ticks)
//  ST_SAMPLE | read pad_data into shadow bit k on the tick (1 tick)
//  ST_CLK    | pad clock high to advance pads to bit k+1 (1 tick)
module joy_poller
   import joy_poller_pkg::*;
#(
   parameter int NUM_PADS   = 4,
   parameter int PAD_BITS   = 8,
   parameter int TICK_DIV   = 128,
   parameter int POLL_GAP   = 1,
   parameter int FOUR_SCORE = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_PADS-1:0]          pad_data,
   output logic                         pad_strobe,
   output logic                         pad_clock,
   output logic [NUM_PADS*PAD_BITS-1:0] pad_state,
   output logic                         pad_valid,
   input  logic                         nes_strobe,
   input  logic [1:0]                   nes_clock,
   output logic [1:0]                   nes_data
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int BIT_W  = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;
   localparam int SUB_W  = $clog2(POLL_GAP + 2);
   localparam int SER_W  = (FOUR_SCORE != 0) ? 24 : PAD_BITS;

   localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(PAD_BITS - 1);
   localparam logic [SUB_W-1:0]  GAP_RELOAD  = SUB_W'(POLL_GAP - 1);
   localparam logic [SUB_W-1:0]  LATCH_TICKS = SUB_W'(1);

   if (FOUR_SCORE != 0 && (NUM_PADS != 4 || PAD_BITS != 8)) begin : g_bad_four_score
      $error("joy_poller: FOUR_SCORE=1 needs NUM_PADS=4 and PAD_BITS=8");
   end
   if (TICK_DIV < 2 || POLL_GAP < 1) begin : g_bad_timing
      $error("joy_poller: TICK_DIV must be >= 2 and POLL_GAP >= 1");
   end

   logic [TICK_W-1:0]                  tick_cnt;
   logic                               tick;
   joy_state_e                         state;
   logic [SUB_W-1:0]                   sub_cnt;
   logic [BIT_W-1:0]                   bit_idx;
   logic [NUM_PADS-1:0][PAD_BITS-1:0]  shadow;
   logic [NUM_PADS-1:0][PAD_BITS-1:0]  shadow_upd;
   logic [SER_W-1:0]                   load_p0;
   logic [SER_W-1:0]                   load_p1;

   assign tick = (tick_cnt == '0);

   // Free-running divider: one tick every TICK_DIV cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         tick_cnt <= TICK_RELOAD;
      end else if (tick) begin
         tick_cnt <= TICK_RELOAD;
      end else begin
         tick_cnt <= tick_cnt - 1'b1;
      end
   end

   // Shadow with the current bit of every pad folded in (pads are active-low).
   always_comb begin
      shadow_upd = shadow;
      for (int n = 0; n < NUM_PADS; n++) begin
         shadow_upd[n][bit_idx] = ~pad_data[n];
      end
   end

   // Poll sequencer; strobe and clock are registered alongside the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_GAP;
         sub_cnt    <= GAP_RELOAD;
         bit_idx    <= '0;
         shadow     <= '0;
         pad_state  <= '0;
         pad_valid  <= 1'b0;
         pad_strobe <= 1'b0;
         pad_clock  <= 1'b0;
      end else begin
         pad_valid <= 1'b0;
         if (tick) begin
            case (state)
               ST_GAP: begin
                  if (sub_cnt == '0) begin
                     state      <= ST_LATCH;
                     sub_cnt    <= LATCH_TICKS;
                     pad_strobe <= 1'b1;
                  end else begin
                     sub_cnt <= sub_cnt - 1'b1;
                  end
               end
               ST_LATCH: begin
                  if (sub_cnt == '0) begin
                     state      <= ST_SAMPLE;
                     bit_idx    <= '0;
                     pad_strobe <= 1'b0;
                  end else begin
                     sub_cnt <= sub_cnt - 1'b1;
                  end
               end
               ST_SAMPLE: begin
                  shadow <= shadow_upd;
                  if (bit_idx == LAST_BIT) begin
                     pad_state <= shadow_upd;
                     pad_valid <= 1'b1;
                     state     <= ST_GAP;
                     sub_cnt   <= GAP_RELOAD;
                  end else begin
                     state     <= ST_CLK;
                     pad_clock <= 1'b1;
                  end
               end
               ST_CLK: begin
                  state     <= ST_SAMPLE;
                  bit_idx   <= bit_idx + 1'b1;
                  pad_clock <= 1'b0;
               end
               default: state <= ST_GAP;
            endcase
         end
      end
   end

   if (FOUR_SCORE != 0) begin : g_four_score
      assign load_p0 = {FS_SIG_P0, pad_state[23:16], pad_state[7:0]};
      assign load_p1 = {FS_SIG_P1, pad_state[31:24], pad_state[15:8]};
   end else begin : g_plain
      assign load_p0 = pad_state[PAD_BITS-1:0];
      if (NUM_PADS > 1) begin : g_pad1
         assign load_p1 = pad_state[PAD_BITS +: PAD_BITS];
      end else begin : g_no_pad1
         assign load_p1 = '0;
      end
   end

   joy_port_shifter #(.W(SER_W)) u_port0 (
      .clock    (clock),
      .reset    (reset),
      .load     (nes_strobe),
      .load_val (load_p0),
      .ser_clk  (nes_clock[0]),
      .ser_out  (nes_data[0])
   );

   joy_port_shifter #(.W(SER_W)) u_port1 (
      .clock    (clock),
      .reset    (reset),
      .load     (nes_strobe),
      .load_val (load_p1),
      .ser_clk  (nes_clock[1]),
      .ser_out  (nes_data[1])
   );

endmodule
